// File: rtl/mc_sequencer.sv
// Multi-cycle control sequencer (FETCH/DECODE/EXEC/MEM/WB/TRAP) for an RV32 subset datapath.
// Optional performance counters are built only when MC_SEQ_PERF_EN is defined.
module mc_sequencer #(
  parameter int oplen = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [oplen-1:0] op,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             iord,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             ir_write,
  output logic             mdr_write,
  output logic             pc_write,
  output logic             pc_src,
  output logic [1:0]       ALUOp,
  output logic             ALUSrc,
  output logic             RegWrite,
  output logic             memtoreg,
  output logic             branch,
  output logic             retire,
  output logic             illegal,
  output logic [2:0]       state,
  output logic [31:0]      cycle_cnt,
  output logic [31:0]      instret_cnt
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  localparam logic [oplen-1:0] OP_R   = oplen'(7'b0110011);
  localparam logic [oplen-1:0] OP_I   = oplen'(7'b0010011);
  localparam logic [oplen-1:0] OP_LW  = oplen'(7'b0000011);
  localparam logic [oplen-1:0] OP_SW  = oplen'(7'b0100011);
  localparam logic [oplen-1:0] OP_BEQ = oplen'(7'b1100011);

  state_t           state_q, state_d;
  logic [oplen-1:0] op_q;
  logic             illegal_q;

  logic is_r, is_i, is_lw, is_sw, is_beq, op_legal;

  // Only DECODE looks at the live op; everything afterwards uses the latched copy.
  assign is_r     = (op_q == OP_R);
  assign is_i     = (op_q == OP_I);
  assign is_lw    = (op_q == OP_LW);
  assign is_sw    = (op_q == OP_SW);
  assign is_beq   = (op_q == OP_BEQ);
  assign op_legal = (op == OP_R) || (op == OP_I) || (op == OP_LW) ||
                    (op == OP_SW) || (op == OP_BEQ);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      op_q      <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE) op_q <= op;
      if (state_d == S_TRAP) illegal_q <= 1'b1;
    end
  end

  // Memory handshake: mem_req is the valid, mem_ready the ready; a transfer
  // completes on a rising edge with both high, and iord/MemRead/MemWrite hold
  // steady for as long as mem_req is high. mem_ready is ignored otherwise.
  always_comb begin
    state_d   = state_q;
    mem_req   = 1'b0;
    iord      = 1'b0;
    MemRead   = 1'b0;
    MemWrite  = 1'b0;
    ir_write  = 1'b0;
    mdr_write = 1'b0;
    pc_write  = 1'b0;
    pc_src    = 1'b0;
    ALUOp     = 2'b00;
    ALUSrc    = 1'b0;
    RegWrite  = 1'b0;
    memtoreg  = 1'b0;
    branch    = 1'b0;
    retire    = 1'b0;
    illegal   = illegal_q;
    state     = state_q;

    case (state_q)
      S_FETCH: begin
        mem_req = 1'b1;
        MemRead = 1'b1;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end
      end
      S_DECODE: begin
        state_d = op_legal ? S_EXEC : S_TRAP;
      end
      S_EXEC: begin
        if (is_r || is_i) begin
          ALUOp   = 2'b10;
          ALUSrc  = is_i;
          state_d = S_WB;
        end else if (is_lw || is_sw) begin
          ALUOp   = 2'b00;
          ALUSrc  = 1'b1;
          state_d = S_MEM;
        end else if (is_beq) begin
          ALUOp    = 2'b01;
          branch   = 1'b1;
          pc_write = zero;
          pc_src   = zero;
          retire   = 1'b1;
          state_d  = S_FETCH;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_MEM: begin
        mem_req  = 1'b1;
        iord     = 1'b1;
        MemRead  = is_lw;
        MemWrite = is_sw;
        if (mem_ready) begin
          if (is_lw) begin
            mdr_write = 1'b1;
            state_d   = S_WB;
          end else begin
            retire  = is_sw;
            state_d = S_FETCH;
          end
        end
      end
      S_WB: begin
        RegWrite = 1'b1;
        memtoreg = is_lw;
        retire   = 1'b1;
        state_d  = S_FETCH;
      end
      S_TRAP: begin
        state_d = S_TRAP;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase

    // Reset wins over everything, so a pending request or write never leaks out.
    if (!rst_n) begin
      mem_req   = 1'b0;
      iord      = 1'b0;
      MemRead   = 1'b0;
      MemWrite  = 1'b0;
      ir_write  = 1'b0;
      mdr_write = 1'b0;
      pc_write  = 1'b0;
      pc_src    = 1'b0;
      ALUOp     = 2'b00;
      ALUSrc    = 1'b0;
      RegWrite  = 1'b0;
      memtoreg  = 1'b0;
      branch    = 1'b0;
      retire    = 1'b0;
      illegal   = 1'b0;
      state     = 3'd0;
    end
  end

`ifdef MC_SEQ_PERF_EN
  logic [31:0] cycle_q, instret_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cycle_q   <= '0;
      instret_q <= '0;
    end else begin
      cycle_q <= cycle_q + 32'd1;
      if (retire) instret_q <= instret_q + 32'd1;
    end
  end

  assign cycle_cnt   = rst_n ? cycle_q : 32'd0;
  assign instret_cnt = rst_n ? instret_q : 32'd0;
`else
  assign cycle_cnt   = 32'd0;
  assign instret_cnt = 32'd0;
`endif

endmodule
